multicycle_ctrl: RTL and testbench

- Control FSM for the multi-cycle MIPS datapath. It replaces the single-cycle control decoder.
- Sequences fetch, decode, execute, memory and write-back over several clocks around a single shared ALU and a single unified memory with a ready handshake.
- Supported instructions: R-type, lw, sw, beq, addi and j.
- Traps on illegal opcodes and on memory time-outs.

---
 rtl/ctrl_pkg.sv | 47 ++++
 rtl/wait_timer.sv | 35 +++
 rtl/multicycle_ctrl.sv | 179 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, states,
// mux select codes and fault codes.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_ILLEGAL = 2'b01,
    FAULT_TIMEOUT = 2'b10
  } fault_e;

endpackage

// File: rtl/wait_timer.sv
// Memory wait counter: clears on request, counts stalled cycles, flags when
// the count has reached TIMEOUT.
module wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int TW      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == TW'(TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/mem/write-back
// around one ALU and one handshaked memory; traps on bad opcodes and timeouts.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int TW      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       iord,
  output logic       mem_rd,
  output logic       dm_we,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic [1:0] fault
);

  state_e state_q, state_d;
  fault_e fault_q, fault_d;
  logic   pc_we_c, ir_we_c, mem_rd_c, dm_we_c, reg_we_c;
  logic   mem_wait, expired;

  assign mem_wait = ~mem_ready &
                    ((state_q == S_FETCH) | (state_q == S_MEM_RD) | (state_q == S_MEM_WR));

  // Any state change restarts the count, so each memory state starts from zero.
  wait_timer #(.TIMEOUT(TIMEOUT), .TW(TW)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_d != state_q),
    .en      (mem_wait),
    .expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    pc_we_c    = 1'b0;
    ir_we_c    = 1'b0;
    mem_rd_c   = 1'b0;
    dm_we_c    = 1'b0;
    reg_we_c   = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALU_ADD;
    pc_src     = PC_ALU;
    case (state_q)
      S_FETCH: begin
        mem_rd_c  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (expired) begin
          state_d = S_TRAP;
          fault_d = FAULT_TIMEOUT;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (op)
          OP_RTYPE: begin
            if (funct != 6'd0) state_d = S_R_EXEC;
            else               state_d = S_FETCH;
          end
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_I_EXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d = S_TRAP;
            fault_d = FAULT_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (op == OP_SW) state_d = S_MEM_WR;
        else             state_d = S_MEM_RD;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_rd_c = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (expired) begin
          state_d = S_TRAP;
          fault_d = FAULT_TIMEOUT;
        end
      end
      S_MEM_WB: begin
        reg_we_c   = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        iord    = 1'b1;
        dm_we_c = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (expired) begin
          state_d = S_TRAP;
          fault_d = FAULT_TIMEOUT;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_we_c = 1'b1;
        reg_dst  = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_we_c   = zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = PC_JUMP;
        pc_we_c = 1'b1;
        state_d = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_we_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: ;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      fault_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // Reset masks every write/request so an interrupted instruction has no side effects.
  assign pc_we  = pc_we_c  & ~rst;
  assign ir_we  = ir_we_c  & ~rst;
  assign mem_rd = mem_rd_c & ~rst;
  assign dm_we  = dm_we_c  & ~rst;
  assign reg_we = reg_we_c & ~rst;
  assign state  = state_q;
  assign fault  = fault_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle stimulus and expected
// state/outputs/fault are queued, then replayed and compared cycle by cycle.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       pc_we, ir_we, iord, mem_rd, dm_we, reg_we, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src, fault;
  logic [3:0] state;
  logic [14:0] obs;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        r;
    logic        mr;
    logic        z;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [3:0]  st;
    logic [14:0] outs;
    logic [1:0]  flt;
  } exp_t;

  exp_t       sb[$];
  logic [5:0] cur_op = 6'd0, cur_fn = 6'd0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(15), .TW(8)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .ir_we(ir_we), .iord(iord), .mem_rd(mem_rd), .dm_we(dm_we),
    .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .state(state), .fault(fault)
  );

  assign obs = {pc_we, ir_we, iord, mem_rd, dm_we, reg_we, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, alu_op, pc_src};

  // Reference output table per state, written straight from the control table.
  function automatic logic [14:0] exp_out(input logic [3:0] st, input logic r,
                                          input logic mr, input logic z);
    logic pw, iw, io, mrd, dw, rw, rd, m2r, sa;
    logic [1:0] bsel, ao, ps;
    {pw, iw, io, mrd, dw, rw, rd, m2r, sa, bsel, ao, ps} = 15'd0;
    case (st)
      4'd0:  begin mrd = 1'b1; bsel = 2'b01; pw = mr; iw = mr; end
      4'd1:  bsel = 2'b11;
      4'd2:  begin sa = 1'b1; bsel = 2'b10; end
      4'd3:  begin io = 1'b1; mrd = 1'b1; end
      4'd4:  begin rw = 1'b1; m2r = 1'b1; end
      4'd5:  begin io = 1'b1; dw = 1'b1; end
      4'd6:  begin sa = 1'b1; ao = 2'b10; end
      4'd7:  begin rw = 1'b1; rd = 1'b1; end
      4'd8:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; pw = z; end
      4'd9:  begin ps = 2'b10; pw = 1'b1; end
      4'd10: begin sa = 1'b1; bsel = 2'b10; end
      4'd11: rw = 1'b1;
      default: ;
    endcase
    if (r) {pw, iw, mrd, dw, rw} = 5'd0;
    return {pw, iw, io, mrd, dw, rw, rd, m2r, sa, bsel, ao, ps};
  endfunction

  task automatic push(input logic r, input logic mr, input logic z, input int st, input int f);
    exp_t e;
    e.r = r; e.mr = mr; e.z = z; e.op = cur_op; e.fn = cur_fn;
    e.st = 4'(st); e.flt = 2'(f);
    e.outs = exp_out(4'(st), r, mr, z);
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    push(1, 1, 0, 0, 0);
    push(1, 1, 0, 0, 0);
    push(0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rst = e.r; mem_ready = e.mr; zero = e.z; op = e.op; funct = e.fn;
      @(negedge clk);
      total++;
      if ({state, obs, fault} !== {e.st, e.outs, e.flt})
        $display("FAIL reset: state=%0d outs=%h fault=%0d want state=%0d outs=%h fault=%0d",
                 state, obs, fault, e.st, e.outs, e.flt);
      if ({state, obs, fault} !== {e.st, e.outs, e.flt}) bad++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    exp_t e;
    cur_op = 6'b000000; cur_fn = 6'b100000;
    push(0, 1, 0, 0, 0); push(0, 1, 0, 1, 0); push(0, 1, 0, 6, 0);
    push(0, 1, 0, 7, 0); push(0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rst = e.r; mem_ready = e.mr; zero = e.z; op = e.op; funct = e.fn;
      @(negedge clk);
      total++;
      if ({state, obs, fault} !== {e.st, e.outs, e.flt}) begin
        bad++;
        $display("FAIL rtype: state=%0d outs=%h fault=%0d want state=%0d outs=%h fault=%0d",
                 state, obs, fault, e.st, e.outs, e.flt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_stall();
    exp_t e;
    cur_op = 6'b100011; cur_fn = 6'd0;
    push(0, 1, 0, 0, 0); push(0, 1, 0, 1, 0); push(0, 1, 0, 2, 0);
    push(0, 0, 0, 3, 0); push(0, 0, 0, 3, 0); push(0, 1, 0, 3, 0);
    push(0, 1, 0, 4, 0); push(0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rst = e.r; mem_ready = e.mr; zero = e.z; op = e.op; funct = e.fn;
      @(negedge clk);
      total++;
      if ({state, obs, fault} !== {e.st, e.outs, e.flt}) begin
        bad++;
        $display("FAIL lw_stall: state=%0d outs=%h fault=%0d want state=%0d outs=%h fault=%0d",
                 state, obs, fault, e.st, e.outs, e.flt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    cur_op = 6'b101011; cur_fn = 6'd0;
    push(0, 1, 0, 0, 0); push(0, 1, 0, 1, 0); push(0, 1, 0, 2, 0); push(0, 1, 0, 5, 0);
    cur_op = 6'b000100;
    push(0, 1, 0, 0, 0); push(0, 1, 0, 1, 0); push(0, 1, 1, 8, 0);
    push(0, 1, 0, 0, 0); push(0, 1, 0, 1, 0); push(0, 1, 0, 8, 0);
    cur_op = 6'b001000;
    push(0, 1, 0, 0, 0); push(0, 1, 0, 1, 0); push(0, 1, 0, 10, 0); push(0, 1, 0, 11, 0);
    cur_op = 6'b000010;
    push(0, 1, 0, 0, 0); push(0, 1, 0, 1, 0); push(0, 1, 0, 9, 0);
    cur_op = 6'b000000; cur_fn = 6'b000000;
    push(0, 1, 0, 0, 0); push(0, 1, 0, 1, 0); push(0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rst = e.r; mem_ready = e.mr; zero = e.z; op = e.op; funct = e.fn;
      @(negedge clk);
      total++;
      if ({state, obs, fault} !== {e.st, e.outs, e.flt}) begin
        bad++;
        $display("FAIL back_to_back op=%b: state=%0d outs=%h fault=%0d want state=%0d outs=%h fault=%0d",
                 e.op, state, obs, fault, e.st, e.outs, e.flt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    cur_op = 6'b111111; cur_fn = 6'd0;
    push(0, 1, 0, 0, 0); push(0, 1, 0, 1, 0);
    for (int i = 0; i < 20; i++) push(0, 1, (i % 2 == 0), 12, 1);
    push(1, 1, 0, 12, 1);
    push(0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rst = e.r; mem_ready = e.mr; zero = e.z; op = e.op; funct = e.fn;
      @(negedge clk);
      total++;
      if ({state, obs, fault} !== {e.st, e.outs, e.flt}) begin
        bad++;
        $display("FAIL illegal: state=%0d outs=%h fault=%0d want state=%0d outs=%h fault=%0d",
                 state, obs, fault, e.st, e.outs, e.flt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    cur_op = 6'b000000; cur_fn = 6'd0;
    push(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) push(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) push(0, 0, 0, 12, 2);
    push(1, 0, 0, 12, 2);
    for (int i = 0; i < 15; i++) push(0, 0, 0, 0, 0);
    push(0, 1, 0, 0, 0); push(0, 0, 0, 1, 0); push(0, 1, 0, 0, 0);
    cur_op = 6'b100011;
    push(0, 1, 0, 1, 0); push(0, 1, 0, 2, 0);
    for (int i = 0; i < 16; i++) push(0, 0, 0, 3, 0);
    push(0, 1, 0, 12, 2);
    push(1, 0, 0, 12, 2);
    push(0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rst = e.r; mem_ready = e.mr; zero = e.z; op = e.op; funct = e.fn;
      @(negedge clk);
      total++;
      if ({state, obs, fault} !== {e.st, e.outs, e.flt}) begin
        bad++;
        $display("FAIL timeout: state=%0d outs=%h fault=%0d want state=%0d outs=%h fault=%0d",
                 state, obs, fault, e.st, e.outs, e.flt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rst_mid_write();
    exp_t e;
    cur_op = 6'b101011; cur_fn = 6'd0;
    push(0, 1, 0, 0, 0); push(0, 1, 0, 1, 0); push(0, 1, 0, 2, 0);
    push(0, 0, 0, 5, 0); push(1, 0, 0, 5, 0); push(0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rst = e.r; mem_ready = e.mr; zero = e.z; op = e.op; funct = e.fn;
      @(negedge clk);
      total++;
      if ({state, obs, fault} !== {e.st, e.outs, e.flt}) begin
        bad++;
        $display("FAIL rst_mid_write: state=%0d outs=%h fault=%0d want state=%0d outs=%h fault=%0d",
                 state, obs, fault, e.st, e.outs, e.flt);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_rst_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
